// File: rtl/p_css32.sv
// p_css32: two-stage pipelined 32-bit carry-select subtractor, diff = a - b - bin.
// Latency: a beat accepted at edge N presents out_valid after edge N+1.
// Backpressure: valid/ready, no skid buffer; holds at most 2 beats, and in_ready follows out_ready combinationally.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   a, b, bin          minuend, subtrahend, borrow-in
//   in_valid/in_ready  operand handshake
//   diff, bout         registered difference (mod 2^32) and borrow-out
//   ovf                registered signed overflow (only when P_CSS32_OVF_EN is defined)
//   out_valid/out_ready result handshake
//
// Build option: define P_CSS32_OVF_EN to add the ovf port and its sign-bit
// pipeline registers. Without it the block is a plain unsigned subtract/compare unit.
//
// Subtraction is carried out as a + ~b + ~bin. A carry out of bit 31 means
// "no borrow", so bout is the inverted final carry.

module p_css32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] diff,
  output logic        bout,
`ifdef P_CSS32_OVF_EN
  output logic        ovf,
`endif
  output logic        out_valid,
  input  logic        out_ready
);

  // ---------------------------------------------------------------------------
  // 4-bit building blocks
  // ---------------------------------------------------------------------------

  // Plain ripple block, used only for the least-significant slice where the
  // true carry-in is known early.
  function automatic logic [4:0] blk_ripple(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       ci);
    logic [4:0] c;
    logic [3:0] s;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[4], s};
  endfunction

  // Carry-select block: both carry-in outcomes are formed in parallel and the
  // late-arriving block carry only drives the final mux.
  function automatic logic [4:0] blk_sel(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       ci);
    logic [4:0] r0;
    logic [4:0] r1;
    r0 = {1'b0, x} + {1'b0, y};
    r1 = {1'b0, x} + {1'b0, y} + 5'd1;
    return ci ? r1 : r0;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic adv2;
  logic accept;

  // S1 moves forward whenever the output register is empty or draining.
  assign adv2     = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: low half (blocks 0..3) and the carry into bit 16
  // ---------------------------------------------------------------------------
  logic [15:0] lo_sum;
  logic        lo_cout;

  always_comb begin
    logic [15:0] nb;
    logic [4:0]  r;
    logic        c;
    nb     = ~b[15:0];
    lo_sum = '0;
    r      = blk_ripple(a[3:0], nb[3:0], ~bin);
    lo_sum[3:0] = r[3:0];
    c      = r[4];
    for (int k = 1; k < 4; k++) begin
      r = blk_sel(a[4*k +: 4], nb[4*k +: 4], c);
      lo_sum[4*k +: 4] = r[3:0];
      c = r[4];
    end
    lo_cout = c;
  end

  logic [15:0] s1_dlo;
  logic        s1_c16;
  logic [15:0] s1_ahi;
  logic [15:0] s1_bhi;
`ifdef P_CSS32_OVF_EN
  logic        s1_asgn;
  logic        s1_bsgn;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dlo   <= '0;
      s1_c16   <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
`ifdef P_CSS32_OVF_EN
      s1_asgn  <= 1'b0;
      s1_bsgn  <= 1'b0;
`endif
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_dlo   <= lo_sum;
      s1_c16   <= lo_cout;
      s1_ahi   <= a[31:16];
      s1_bhi   <= b[31:16];
`ifdef P_CSS32_OVF_EN
      s1_asgn  <= a[31];
      s1_bsgn  <= b[31];
`endif
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: high half (blocks 4..7), all carry-select, seeded by the
  // registered carry into bit 16
  // ---------------------------------------------------------------------------
  logic [15:0] hi_sum;
  logic        hi_cout;

  always_comb begin
    logic [15:0] nb;
    logic [4:0]  r;
    logic        c;
    nb     = ~s1_bhi;
    hi_sum = '0;
    r      = '0;
    c      = s1_c16;
    for (int k = 0; k < 4; k++) begin
      r = blk_sel(s1_ahi[4*k +: 4], nb[4*k +: 4], c);
      hi_sum[4*k +: 4] = r[3:0];
      c = r[4];
    end
    hi_cout = c;
  end

  logic [31:0] diff_n;
  logic        bout_n;

  assign diff_n = {hi_sum, s1_dlo};
  assign bout_n = ~hi_cout;

`ifdef P_CSS32_OVF_EN
  // Signed overflow: operands of opposite sign and the result sign differs
  // from the minuend sign.
  logic ovf_n;
  assign ovf_n = (s1_asgn ^ s1_bsgn) & (diff_n[31] ^ s1_asgn);
`endif

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
`ifdef P_CSS32_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (adv2) begin
      out_valid <= 1'b1;
      diff      <= diff_n;
      bout      <= bout_n;
`ifdef P_CSS32_OVF_EN
      ovf       <= ovf_n;
`endif
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p_css32.sv
// tb_p_css32: randomized and directed bench for p_css32 against a queue-based
// reference model (33-bit arithmetic, beat-count occupancy, fixed 2-edge latency).
// Define P_CSS32_OVF_EN to also exercise the overflow output.

module tb_p_css32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] diff;
  logic        bout;
`ifdef P_CSS32_OVF_EN
  logic        ovf;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;

  p_css32 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef P_CSS32_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        hold_vld = 1'b0;
  logic [31:0] hold_diff = '0;
  logic        hold_bout = 1'b0;
  logic        use_dir = 1'b0;
  exp_t        dir_exp;
  logic        saw_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
    exp_t e;
    logic [32:0] r;
    r    = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    e.d  = r[31:0];
    e.bo = r[32];
    e.ov = (ma[31] != mb[31]) && (r[31] != ma[31]);
    e.acc = 0;
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 time unit later,
  // and account for the transfers that will happen at the next rising edge.
  task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ibin, input logic ordy, output logic acc);
    int   n;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    bin       = ibin;
    out_ready = ordy;
    #1;
    acc = 1'b0;
    if (!rst) begin
      n = q.size();
      check("in_ready", in_ready, (n < 2) || ordy);
      if (iv && !in_ready) saw_stall = 1'b1;
      check("out_valid", out_valid, (n > 0) && (cyc - q[0].acc >= 2));
      if (hold_vld) begin
        check("stall_diff", diff, hold_diff);
        check("stall_bout", bout, hold_bout);
      end
      if (out_valid && ordy && n > 0) begin
        e = q.pop_front();
        check("diff", diff, e.d);
        check("bout", bout, e.bo);
`ifdef P_CSS32_OVF_EN
        check("ovf", ovf, e.ov);
`endif
      end
      hold_vld  = out_valid && !ordy;
      hold_diff = diff;
      hold_bout = bout;
      acc = iv && in_ready;
      if (acc) begin
        e = use_dir ? dir_exp : model(ia, ib, ibin);
        e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("drain_empty", q.size(), 0);
  endtask

  task automatic send_dir(input logic [31:0] da, input logic [31:0] db, input logic dbin,
                          input logic [31:0] ed, input logic ebo, input logic eov);
    logic acc;
    acc      = 1'b0;
    use_dir  = 1'b1;
    dir_exp.d  = ed;
    dir_exp.bo = ebo;
    dir_exp.ov = eov;
    dir_exp.acc = 0;
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, da, db, dbin, 1'b1, acc);
    use_dir = 1'b0;
    check("dir_accept", acc, 1'b1);
    drain();
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0001_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic acc;
    int   sent;

    // Reset state, including in_ready during reset.
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_diff", diff, 32'h0);
    check("rst_bout", bout, 1'b0);
`ifdef P_CSS32_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with fixed expected results.
    send_dir(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    send_dir(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send_dir(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    send_dir(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
    send_dir(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    send_dir(32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);

    // Backpressure: 6 back-to-back beats, downstream stalled in cycles 2..5.
    sent = 0;
    saw_stall = 1'b0;
    for (int t = 0; t < 40 && sent < 6; t++) begin
      cycle(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
            !(t >= 2 && t <= 5), acc);
      if (acc) sent++;
    end
    check("bp_sent", sent, 6);
    check("bp_in_ready_dropped", saw_stall, 1'b1);
    drain();

    // Randomized traffic with random downstream stalls.
    for (int t = 0; t < 400; t++)
      cycle(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), acc);
    drain();

    // Reset with two beats in flight.
    cycle(1'b1, 32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    check("inflight_count", q.size(), 2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_diff", diff, 32'h0);
    check("midrst_bout", bout, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    q.delete();
    hold_vld = 1'b0;
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    rst = 1'b0;
    // Idle after release: any out_valid would be a stale beat.
    for (int t = 0; t < 6; t++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    send_dir(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
